// File: rtl/mig_pkg.sv
// Shared definitions for the MIG read-port arbiter: command codes, FSM states
// and default field widths.
package mig_pkg;

  localparam int MIG_AW  = 30;
  localparam int MIG_BLW = 6;

  localparam logic [2:0] MIG_CMD_RD = 3'b001;
  localparam logic [2:0] MIG_CMD_WR = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mig_rd_arbiter_if.sv
// MIG-style command and read-FIFO port; the arbiter is master, the memory
// controller is slave.
interface mig_rd_arbiter_if
  import mig_pkg::*;
#(
  parameter int AW  = MIG_AW,
  parameter int BLW = MIG_BLW
);

  logic           cmd_en;
  logic [2:0]     cmd_instr;
  logic [BLW-1:0] cmd_bl;
  logic [AW-1:0]  cmd_byte_addr;
  logic           cmd_full;
  logic           rd_en;
  logic [31:0]    rd_data;
  logic           rd_empty;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en,
    input  cmd_full, rd_data, rd_empty
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en,
    output cmd_full, rd_data, rd_empty
  );

endinterface

// File: rtl/mig_rd_arbiter_rr_arb2.sv
// Two-way round-robin selector; the last-grant pointer resets to 1 so
// requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       sel
);

  logic last_q;

  always_comb begin
    valid = |req;
    sel   = 1'b0;
    if (req == 2'b10)
      sel = 1'b1;
    else if (req == 2'b11)
      sel = ~last_q;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b1;
    else if (take && valid)
      last_q <= sel;
  end

endmodule

// File: rtl/mig_rd_arbiter.sv
// Shares one MIG command/read port between I-cache (0) and D-cache (1) fills:
// round-robin grant, one burst read per grant, per-beat watchdog.
module mig_rd_arbiter
  import mig_pkg::*;
#(
  parameter int AW      = MIG_AW,
  parameter int BLW     = MIG_BLW,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [AW-1:0]     adr0,
  input  logic [BLW-1:0]    bl0,
  output logic              gnt0,
  output logic              dv0,
  output logic              done0,
  output logic              err0,
  input  logic              req1,
  input  logic [AW-1:0]     adr1,
  input  logic [BLW-1:0]    bl1,
  output logic              gnt1,
  output logic              dv1,
  output logic              done1,
  output logic              err1,
  output logic [31:0]       rd_dat,
  mig_rd_arbiter_if.master  mem
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  // Abort on the empty cycle that would take the counter to TIMEOUT-1, so
  // err is visible in the cycle the counter reaches that value.
  localparam logic [TW-1:0] TO_ABORT = TW'(TIMEOUT - 2);
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  state_t         state;
  logic           owner;
  logic [AW-1:0]  addr_q;
  logic [BLW-1:0] bl_q;
  logic [BLW-1:0] beat_q;
  logic [TW-1:0]  tcnt_q;
  logic           cmd_en_q;
  logic [1:0]     err_q;
  logic [31:0]    dat_q;
  logic           arb_valid;
  logic           arb_sel;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({req1, req0}),
    .take  (state == IDLE),
    .valid (arb_valid),
    .sel   (arb_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      addr_q   <= '0;
      bl_q     <= '0;
      beat_q   <= '0;
      tcnt_q   <= '0;
      cmd_en_q <= 1'b0;
      err_q    <= '0;
      dat_q    <= '0;
    end else begin
      cmd_en_q <= 1'b0;
      err_q    <= '0;
      if (mem.rd_en)
        dat_q <= mem.rd_data;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            owner  <= arb_sel;
            addr_q <= (arb_sel ? adr1 : adr0) & WORD_MASK;
            bl_q   <= arb_sel ? bl1 : bl0;
            state  <= CMD;
          end
        end
        CMD: begin
          if (!mem.cmd_full) begin
            cmd_en_q <= 1'b1;
            beat_q   <= '0;
            tcnt_q   <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (mem.rd_en) begin
            beat_q <= beat_q + 1'b1;
            tcnt_q <= '0;
            if (beat_q == bl_q)
              state <= DONE;
          end else if (tcnt_q == TO_ABORT) begin
            err_q[owner] <= 1'b1;
            state        <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem.rd_en         = (state == READ) && !mem.rd_empty;
    mem.cmd_en        = cmd_en_q;
    mem.cmd_instr     = cmd_en_q ? MIG_CMD_RD : '0;
    mem.cmd_bl        = cmd_en_q ? bl_q : '0;
    mem.cmd_byte_addr = cmd_en_q ? addr_q : '0;
    rd_dat            = mem.rd_en ? mem.rd_data : dat_q;
    gnt0              = (state != IDLE) && !owner;
    gnt1              = (state != IDLE) && owner;
    dv0               = mem.rd_en && !owner;
    dv1               = mem.rd_en && owner;
    done0             = (state == DONE) && !owner;
    done1             = (state == DONE) && owner;
    err0              = err_q[0];
    err1              = err_q[1];
  end

endmodule

// File: tb/tb_mig_rd_arbiter.sv
// Directed bench for mig_rd_arbiter: cycle table for a single burst plus
// hand sequences for contention, backpressure, bubbles, timeout and reset.
module tb_mig_rd_arbiter;

  localparam int AW  = 30;
  localparam int BLW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [AW-1:0]  adr0, adr1;
  logic [BLW-1:0] bl0, bl1;
  logic           gnt0, dv0, done0, err0;
  logic           gnt1, dv1, done1, err1;
  logic [31:0]    rd_dat;

  int n_chk  = 0;
  int n_fail = 0;

  mig_rd_arbiter_if #(.AW(AW), .BLW(BLW)) mif ();

  mig_rd_arbiter #(.AW(AW), .BLW(BLW), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .adr0  (adr0),
    .bl0   (bl0),
    .gnt0  (gnt0),
    .dv0   (dv0),
    .done0 (done0),
    .err0  (err0),
    .req1  (req1),
    .adr1  (adr1),
    .bl1   (bl1),
    .gnt1  (gnt1),
    .dv1   (dv1),
    .done1 (done1),
    .err1  (err1),
    .rd_dat(rd_dat),
    .mem   (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req0;
    logic        rd_empty;
    logic [31:0] rd_data;
    logic [9:0]  exp_o;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {gnt0,gnt1,dv0,dv1,done0,done1,err0,err1,cmd_en,rd_en}
  function automatic logic [9:0] outs();
    return {gnt0, gnt1, dv0, dv1, done0, done1, err0, err1, mif.cmd_en, mif.rd_en};
  endfunction

  function automatic logic [38:0] cmdf();
    return {mif.cmd_instr, mif.cmd_bl, mif.cmd_byte_addr};
  endfunction

  function automatic logic [3:0] side(input bit who);
    return who ? {gnt1, dv1, done1, err1} : {gnt0, dv0, done0, err0};
  endfunction

  task automatic set_req(input bit who, input logic v);
    if (who) req1 = v; else req0 = v;
  endtask

  // One complete burst for requester `who`, starting in an IDLE cycle.
  task automatic do_burst(input bit who, input logic [AW-1:0] adr, input logic [AW-1:0] exp_addr,
                          input logic [BLW-1:0] bl, input int full_cyc, input bit bubbles,
                          input bit keep, input bit drop_mid);
    int beats, gap, budget;
    logic [31:0] base;
    base = who ? 32'hD100_0000 : 32'hC000_0000;
    if (who) begin adr1 = adr; bl1 = bl; end else begin adr0 = adr; bl0 = bl; end
    set_req(who, 1'b1);
    mif.rd_empty = 1'b1;
    for (int k = 0; k <= full_cyc + 2; k++) begin
      mif.cmd_full = (k >= 1 && k <= full_cyc);
      #1;
      check("gnt_owner", side(who) >> 3, (k >= 1));
      check("nonowner_quiet", side(!who), 4'b0);
      check("cmd_en_timing", mif.cmd_en, (k == full_cyc + 2));
      if (k == full_cyc + 2)
        check("cmd_fields", cmdf(), {3'b001, bl, exp_addr});
      tick();
    end
    mif.cmd_full = 1'b0;
    beats = 0; gap = 0; budget = 0;
    while (beats <= int'(bl) && budget < 4000) begin
      mif.rd_empty = (bubbles && gap < 10 && $urandom_range(0, 2) == 0);
      mif.rd_data  = base + beats;
      if (drop_mid && beats == 1) set_req(who, 1'b0);
      #1;
      check("rd_en_vs_empty", mif.rd_en, !mif.rd_empty);
      check("dv_owner", (side(who) >> 2) & 4'b1, !mif.rd_empty);
      check("nonowner_quiet", side(!who), 4'b0);
      if (!mif.rd_empty) begin
        check("rd_dat_beat", rd_dat, base + beats);
        beats++;
        gap = 0;
      end else begin
        gap++;
      end
      tick();
      budget++;
    end
    check("beats_within_budget", (budget < 4000), 1'b1);
    mif.rd_empty = 1'b1;
    #1;
    check("done_cycle", side(who), 4'b1010);
    check("nonowner_quiet", side(!who), 4'b0);
    check("rd_dat_hold", rd_dat, base + 32'(bl));
    if (!keep) set_req(who, 1'b0);
    tick();
    check("after_done", side(who), 4'b0);
  endtask

  initial begin
    int n, err_at;
    bit seen;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    adr0 = '0; adr1 = '0; bl0 = '0; bl1 = '0;
    mif.cmd_full = 1'b0; mif.rd_data = '0; mif.rd_empty = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 32'h0, 10'h000, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0, 10'h200, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h0, 10'h202, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'hA000_0000, 10'h281, 32'hA000_0000};
    tbl[4] = '{1'b1, 1'b0, 32'hA000_0001, 10'h281, 32'hA000_0001};
    tbl[5] = '{1'b1, 1'b0, 32'hA000_0002, 10'h281, 32'hA000_0002};
    tbl[6] = '{1'b1, 1'b0, 32'hA000_0003, 10'h281, 32'hA000_0003};
    tbl[7] = '{1'b0, 1'b1, 32'h0, 10'h220, 32'hA000_0003};
    tbl[8] = '{1'b0, 1'b1, 32'h0, 10'h000, 32'hA000_0003};

    tick(); tick();
    #1;
    check("reset_outs", outs(), 10'h0);
    check("reset_rd_dat", rd_dat, 32'h0);
    check("reset_cmd", cmdf(), 39'h0);
    rst = 1'b0;
    tick();

    // Single burst, cycle by cycle
    adr0 = 30'h3FFF_F000; bl0 = 6'd3;
    for (int i = 0; i < 9; i++) begin
      req0 = tbl[i].req0;
      mif.rd_empty = tbl[i].rd_empty;
      mif.rd_data  = tbl[i].rd_data;
      #1;
      check($sformatf("tbl_outs[%0d]", i), outs(), tbl[i].exp_o);
      check($sformatf("tbl_rd_dat[%0d]", i), rd_dat, tbl[i].exp_dat);
      if (tbl[i].exp_o[1])
        check("tbl_cmd", cmdf(), {3'b001, 6'd3, 30'h3FFF_F000});
      else
        check("tbl_cmd_zero", cmdf(), 39'h0);
      tick();
    end

    // Contention from reset: 0, 1, 0, 1
    rst = 1'b1; tick(); rst = 1'b0;
    req1 = 1'b1; adr1 = 30'h0000_0200; bl1 = 6'd1;
    do_burst(1'b0, 30'h0000_0100, 30'h0000_0100, 6'd1, 0, 1'b0, 1'b1, 1'b0);
    do_burst(1'b1, 30'h0000_0200, 30'h0000_0200, 6'd1, 0, 1'b0, 1'b1, 1'b0);
    do_burst(1'b0, 30'h0000_0100, 30'h0000_0100, 6'd1, 0, 1'b0, 1'b1, 1'b0);
    do_burst(1'b1, 30'h0000_0200, 30'h0000_0200, 6'd1, 0, 1'b0, 1'b0, 1'b0);
    req0 = 1'b0;
    tick();

    // Backpressure, bubbles with alignment and mid-burst req drop, bl extremes
    do_burst(1'b0, 30'h0000_1000, 30'h0000_1000, 6'd2, 5, 1'b0, 1'b0, 1'b0);
    do_burst(1'b1, 30'h0000_0106, 30'h0000_0104, 6'd7, 0, 1'b1, 1'b0, 1'b1);
    do_burst(1'b0, 30'h0000_0023, 30'h0000_0020, 6'd0, 0, 1'b0, 1'b0, 1'b0);
    do_burst(1'b1, 30'h0000_03F0, 30'h0000_03F0, 6'd63, 0, 1'b1, 1'b0, 1'b0);

    // Timeout after 2 of 4 beats
    req0 = 1'b1; adr0 = 30'h0000_2000; bl0 = 6'd3; mif.rd_empty = 1'b1;
    tick(); tick();
    #1;
    check("to_cmd_en", mif.cmd_en, 1'b1);
    tick();
    for (int b = 0; b < 2; b++) begin
      mif.rd_empty = 1'b0; mif.rd_data = 32'h5500_0000 + b;
      #1;
      check("to_dv0", dv0, 1'b1);
      tick();
    end
    mif.rd_empty = 1'b1;
    n = 0; seen = 1'b0; err_at = -1;
    while (!seen && n < 40) begin
      n++;
      #1;
      check("to_no_done", {done0, done1, err1}, 3'b0);
      if (err0) begin
        seen = 1'b1; err_at = n; req0 = 1'b0;
        check("to_gnt_dropped", {gnt0, gnt1}, 2'b0);
      end else begin
        tick();
      end
    end
    check("to_err_cycle", err_at, 16);
    tick();
    check("to_err_pulse", err0, 1'b0);
    mif.rd_empty = 1'b0; mif.rd_data = 32'h5500_0002;
    #1;
    check("to_late_beat", {mif.rd_en, dv0, dv1, gnt0, gnt1}, 5'b0);
    mif.rd_empty = 1'b1;
    tick();
    do_burst(1'b1, 30'h0000_3000, 30'h0000_3000, 6'd1, 0, 1'b0, 1'b0, 1'b0);

    // Reset after beat 2 of 8
    req0 = 1'b1; adr0 = 30'h0000_0040; bl0 = 6'd7;
    tick(); tick(); tick();
    for (int b = 0; b < 2; b++) begin
      mif.rd_empty = 1'b0; mif.rd_data = 32'h7700_0000 + b;
      #1;
      check("rst_dv0", dv0, 1'b1);
      tick();
    end
    mif.rd_empty = 1'b1; rst = 1'b1; req0 = 1'b0;
    tick();
    #1;
    check("rst_mid_outs", outs(), 10'h0);
    check("rst_mid_rd_dat", rd_dat, 32'h0);
    check("rst_mid_cmd", cmdf(), 39'h0);
    rst = 1'b0;
    tick();
    do_burst(1'b0, 30'h0000_0080, 30'h0000_0080, 6'd7, 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mig_rd_arbiter.md
Name: mig_rd_arbiter

Overview:
- Shares the single MIG-style memory command/read port between two read requesters: requester 0 is the instruction-cache fill and requester 1 is the data-cache fill.
- Arbitrates round-robin, issues one burst read command per grant, and streams returned beats to the owner.
- A per-beat watchdog aborts hung bursts.
- Sits between the Raptor64 cache-fill logic and the external memory controller port.

Parameters:
- AW, 30, byte address width on both sides.
- BLW, 6, burst-length field width; the value is beats-1.
- TIMEOUT, 1024, maximum cycles between consecutive beats (or from command to first beat) before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 read request; held until done0 or err0
- adr0  in  AW  requester 0 byte address
- bl0  in  BLW  requester 0 beats-1
- gnt0  out  1  requester 0 owns the port (CMD through DONE)
- dv0  out  1  rd_dat valid for requester 0 this cycle
- done0  out  1  one-cycle pulse: requester 0 burst complete
- err0  out  1  one-cycle pulse: requester 0 burst aborted by timeout
- req1/adr1/bl1/gnt1/dv1/done1/err1  same for requester 1
- rd_dat  out  32  beat data, shared by both requesters
- cmd_en  out  1  command strobe to the memory controller
- cmd_instr  out  3  command code; always 3'b001 (read)
- cmd_bl  out  BLW  burst length, beats-1
- cmd_byte_addr  out  AW  word-aligned byte address
- cmd_full  in  1  controller command FIFO full
- rd_en  out  1  pop the controller read FIFO
- rd_data  in  32  controller read data (first-word-fall-through)
- rd_empty  in  1  controller read FIFO empty

Behaviour:
- Reset values: all outputs are 0, state is IDLE, the last-grant pointer is 1 (so requester 0 wins first), and the beat and timeout counters are 0.
- States are IDLE, CMD, READ and DONE.
- IDLE:
  - Only req0 set: grant 0. Only req1 set: grant 1.
  - Both set: grant the requester not granted last.
  - On a grant: latch owner, address (bits[1:0] forced to 0), and bl; update the last-grant pointer; assert gntN from the next cycle; go to CMD.
  - No request: stay in IDLE.
- CMD:
  - While cmd_full=1, hold with cmd_en=0.
  - On the first cycle with cmd_full=0, drive cmd_en=1 for exactly one cycle, with cmd_instr=3'b001, cmd_bl=latched bl and cmd_byte_addr=latched address.
  - Then go to READ with the beat counter and timeout counter cleared.
  - cmd_instr, cmd_bl and cmd_byte_addr are 0 whenever cmd_en=0.
- READ:
  - rd_en = !rd_empty (combinational).
  - On each cycle with rd_en=1: rd_dat=rd_data, dvN=1 for the owner, the beat counter increments, and the timeout counter clears.
  - After the beat with beat counter == latched bl: go to DONE.
  - Every cycle with rd_empty=1: the timeout counter increments.
  - Timeout counter reaching TIMEOUT-1: pulse errN, drop gntN, go to IDLE. Beats arriving later belong to no one and are not popped.
- DONE:
  - Pulse doneN for one cycle, drop gntN, go to IDLE.
  - A new grant can be issued on the cycle after DONE, so the minimum gap between commands is 1 idle cycle.
- Boundary conditions:
  - A requester deasserting req mid-burst is ignored; the burst completes and dv/done still pulse.
  - bl=0 gives a single beat.
  - bl=63 gives 64 beats; the counter must not wrap early.
  - rd_empty bubbles between beats are tolerated without limit up to TIMEOUT.
  - rd_dat holds its last value when dv=0.
  - The non-owner's dv, done, err and gnt stay 0 at all times.
  - Reset mid-operation returns everything to reset values immediately. The memory controller is reset by the same rst, so there is no drain.
- Latency: req to cmd_en is 2 cycles when cmd_full=0. The first dv follows rd_empty falling in the same cycle.

Decomposition:
- Package mig_pkg holds:
  - MIG_CMD_RD=3'b001 and MIG_CMD_WR=3'b000;
  - the state enum (IDLE, CMD, READ, DONE);
  - the AW and BLW defaults.
- One natural sub-module, rr_arb2, is the 2-way round-robin grant with a last-grant pointer. The timeout counter stays inline.

Test Plan:
- Single burst: req0 with adr0=30'h3FFF_F000 and bl0=3, rd_empty low for 4 cycles → 2 cycles after req0, cmd_en pulses once with cmd_instr=001, cmd_bl=3 and cmd_byte_addr=30'h3FFF_F000; dv0 pulses 4 times with the FIFO words in order; done0 pulses the cycle after the 4th beat; gnt1 and dv1 stay 0.
- Contention: req0 and req1 both asserted after reset, bl=1 each → requester 0 is served first, then requester 1. A further simultaneous request then grants 1 first only if 0 was last; alternation is verified over 4 rounds.
- Backpressure: cmd_full high for 5 cycles at grant → cmd_en stays 0 for those cycles, then is high for exactly one cycle after cmd_full falls.
- Bubbles and alignment: adr1=30'h0000_0106 with bl1=7 → cmd_byte_addr=30'h0000_0104. rd_empty is toggled randomly with every gap shorter than TIMEOUT → exactly 8 dv1 pulses, rd_en never high while rd_empty=1, then done1.
- Timeout: TIMEOUT=16, bl0=3, only 2 beats delivered → err0 pulses 16 cycles after the 2nd beat, done0 never asserts, the arbiter returns to IDLE, and a following req1 is granted normally.
- Reset mid-burst: rst asserted after beat 2 of 8 → the next cycle has all outputs 0; after rst deasserts, a new req0 completes normally.
